// File: rtl/imm_encoder_loader_if.sv
// Bundles the loader's session control, input stream and instruction-memory write port.
// The slave modport is the loader's view; the master modport is the view of its environment.
interface imm_encoder_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              start;
  logic [ADDR_W:0]   num_words;
  logic              busy;
  logic              done;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_immSrc;
  logic [31:0]       in_imm;
  logic [31:0]       in_base;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              err;
  logic [ADDR_W-1:0] err_addr;

  modport slave (
    input  start, num_words, in_valid, in_immSrc, in_imm, in_base,
    output busy, done, in_ready, imem_we, imem_addr, imem_wdata, err, err_addr
  );

  modport master (
    output start, num_words, in_valid, in_immSrc, in_imm, in_base,
    input  busy, done, in_ready, imem_we, imem_addr, imem_wdata, err, err_addr
  );
endinterface

// File: rtl/imm_encoder_loader.sv
// Packs signed immediates into I/S/B/J fields of a base instruction and streams them into imem.
// Optional macro IMM_RANGE_CHECK_EN adds a sticky immediate range/alignment error with its address.
module imm_encoder_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imm_encoder_loader_if.slave  bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0]  r_remaining;
  logic              r_busy;
  logic              r_done;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_last;
  logic              w_start_idle;
  logic [31:0]       w_enc;

  assign w_in_ready   = (r_state == S_LOAD) && (r_remaining != '0);
  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_last       = (r_remaining == CNT_W'(1));
  assign w_start_idle = (r_state == S_IDLE) && bus.start;

  // Scatter immediate bits over the format's fields; everything else passes from in_base.
  always_comb begin
    w_enc = bus.in_base;
    case (bus.in_immSrc)
      2'b00: w_enc[31:20] = bus.in_imm[11:0];
      2'b01: begin
        w_enc[31:25] = bus.in_imm[11:5];
        w_enc[11:7]  = bus.in_imm[4:0];
      end
      2'b10: begin
        w_enc[31]    = bus.in_imm[12];
        w_enc[7]     = bus.in_imm[11];
        w_enc[30:25] = bus.in_imm[10:5];
        w_enc[11:8]  = bus.in_imm[4:1];
      end
      default: begin
        w_enc[31]    = bus.in_imm[20];
        w_enc[30:21] = bus.in_imm[10:1];
        w_enc[20]    = bus.in_imm[11];
        w_enc[19:12] = bus.in_imm[19:12];
      end
    endcase
  end

  // Session FSM; the write port is registered one cycle behind the accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_wr_ptr    <= ADDR_W'(BASE_ADDR);
            r_remaining <= bus.num_words;
            if (bus.num_words != '0) begin
              r_state <= S_LOAD;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_we        <= 1'b1;
            r_addr      <= r_wr_ptr;
            r_wdata     <= w_enc;
            r_wr_ptr    <= r_wr_ptr + ADDR_W'(1);
            r_remaining <= r_remaining - CNT_W'(1);
            if (w_last) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.in_ready   = w_in_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;

`ifdef IMM_RANGE_CHECK_EN
  logic              r_err;
  logic [ADDR_W-1:0] r_err_addr;
  logic              w_range_bad;

  // The immediate must survive truncation to its field; B/J offsets must also be even.
  always_comb begin
    w_range_bad = 1'b0;
    case (bus.in_immSrc)
      2'b00, 2'b01: w_range_bad = (bus.in_imm != {{20{bus.in_imm[11]}}, bus.in_imm[11:0]});
      2'b10: w_range_bad = (bus.in_imm != {{19{bus.in_imm[12]}}, bus.in_imm[12:0]}) || bus.in_imm[0];
      default: w_range_bad = (bus.in_imm != {{11{bus.in_imm[20]}}, bus.in_imm[20:0]}) || bus.in_imm[0];
    endcase
  end

  // Sticky until the next start; the address freezes on the first offender.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else if (w_start_idle) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else if (w_accept && w_range_bad) begin
      r_err <= 1'b1;
      if (!r_err) begin
        r_err_addr <= r_wr_ptr;
      end
    end
  end

  assign bus.err      = r_err;
  assign bus.err_addr = r_err_addr;
`else
  logic w_unused_imm;
  assign w_unused_imm = ^{bus.in_imm[31:21], w_start_idle};
  assign bus.err      = 1'b0;
  assign bus.err_addr = '0;
`endif

endmodule
